ps2_frame_ctrl: RTL and testbench

PS2_FRAME_CTRL -- requirements
Module: ps2_frame_ctrl

---
 rtl/ps2_frame_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_ps2_frame_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_frame_ctrl.sv
// PS/2 device-to-host receiver: pin synchronizers, clock glitch filter, frame FSM
// with timeout, and a show-ahead receive FIFO. Define PS2_PARITY_CHECK_EN to reject bad-parity frames.
module ps2_frame_ctrl #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 10000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic       frame_err,
  output logic       ovf,
  input  logic       clr_ovf,
  output logic       busy,
  output logic [1:0] dbg_state
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3} state_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic [FW-1:0] filt_cnt;
  logic          clk_f, clk_f_d, fall_p;

  state_t        state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift, shift_n;
  logic          par_bit, par_bit_n, par_ok;
  logic [TW-1:0] to_cnt, to_cnt_n;
  logic          push_n, err_n, push;
  logic [7:0]    push_byte;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          pop, full, do_push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // clk_f follows clk_s2 only after FILTER_LEN samples in a row disagree with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_cnt <= '0;
      clk_f    <= 1'b1;
      clk_f_d  <= 1'b1;
    end else begin
      clk_f_d <= clk_f;
      if (clk_s2 == clk_f) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_f    <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fall_p = clk_f_d & ~clk_f;

`ifdef PS2_PARITY_CHECK_EN
  assign par_ok = ^{shift, par_bit};
`else
  // parity bit is still captured, its value simply never rejects a frame
  assign par_ok = (^{shift, par_bit}) | 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      par_bit   <= 1'b0;
      to_cnt    <= '0;
      push      <= 1'b0;
      push_byte <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shift     <= shift_n;
      par_bit   <= par_bit_n;
      to_cnt    <= to_cnt_n;
      push      <= push_n;
      frame_err <= err_n;
      if (push_n) push_byte <= shift;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    par_bit_n = par_bit;
    to_cnt_n  = to_cnt;
    push_n    = 1'b0;
    err_n     = 1'b0;
    if (state != IDLE) to_cnt_n = fall_p ? '0 : to_cnt + 1'b1;
    case (state)
      IDLE: begin
        to_cnt_n = '0;
        if (fall_p) begin
          if (!dat_s2) begin
            state_n   = DATA;
            bit_cnt_n = '0;
            shift_n   = '0;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      DATA: if (fall_p) begin
        shift_n   = {dat_s2, shift[7:1]};
        bit_cnt_n = bit_cnt + 1'b1;
        if (bit_cnt == 3'd7) state_n = PARITY;
      end
      PARITY: if (fall_p) begin
        par_bit_n = dat_s2;
        state_n   = STOP;
      end
      STOP: if (fall_p) begin
        state_n = IDLE;
        if (dat_s2 && par_ok) push_n = 1'b1;
        else                  err_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    // stalled line: drop the partial frame
    if (state != IDLE && !fall_p && to_cnt == TW'(TIMEOUT_CYC - 1)) begin
      state_n   = IDLE;
      bit_cnt_n = '0;
      shift_n   = '0;
      to_cnt_n  = '0;
      push_n    = 1'b0;
      err_n     = 1'b1;
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // Consumer handshake: a byte leaves the FIFO on any rising clk edge where
  // rd_valid and rd_ready are both high; rd_data shows the head while rd_valid.
  assign rd_valid = (count != '0);
  assign pop      = rd_ready && rd_valid;
  assign full     = (count == CW'(FIFO_DEPTH));
  assign do_push  = push && (!full || pop);
  assign rd_data  = rd_valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_byte;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !pop)      count <= count + 1'b1;
      else if (!do_push && pop) count <= count - 1'b1;
      if (push && full && !pop) ovf <= 1'b1;
      else if (clr_ovf)         ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_frame_ctrl.sv
// Directed bench for ps2_frame_ctrl: bit-banged PS/2 frames, expected bytes
// queued as frames are sent and compared as they are popped from the FIFO.
module tb_ps2_frame_ctrl;

  localparam int FL   = 4;
  localparam int TO   = 200;
  localparam int FD   = 4;
  localparam int HALF = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd_ready = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid, frame_err, ovf, busy;
  logic [1:0] dbg_state;

  int n_pass = 0;
  int n_total = 0;
  int err_cnt = 0;
  int e0;
  logic [7:0] exp_q[$];
  logic model_ovf = 1'b0;

  ps2_frame_ctrl #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .frame_err(frame_err), .ovf(ovf), .clr_ovf(clr_ovf), .busy(busy),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err === 1'b1) err_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

  // data changes while ps2_clk is high; optional short glitches in both phases
  task automatic send_bit(input logic b, input logic glitch);
    ps2_data = b;
    if (glitch) begin
      cycles(3); ps2_clk = 1'b0; cycles(2); ps2_clk = 1'b1; cycles(HALF - 5);
      ps2_clk = 1'b0;
      cycles(3); ps2_clk = 1'b1; cycles(2); ps2_clk = 1'b0; cycles(HALF - 5);
    end else begin
      cycles(HALF);
      ps2_clk = 1'b0;
      cycles(HALF);
    end
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input logic glitch);
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(d[i], glitch);
    send_bit(par, glitch);
    send_bit(stp, glitch);
    ps2_data = 1'b1;
    cycles(HALF);
  endtask

  task automatic expect_byte(input logic [7:0] d);
    if (exp_q.size() < FD) exp_q.push_back(d);
    else model_ovf = 1'b1;
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    @(negedge clk);
    while (rd_valid === 1'b1 && guard < FD + 2) begin
      if (exp_q.size() == 0) check({tag, "_spurious"}, {31'd0, rd_valid}, 32'd0);
      else                   check({tag, "_data"}, {24'd0, rd_data}, {24'd0, exp_q.pop_front()});
      rd_ready = 1'b1;
      @(negedge clk);
      rd_ready = 1'b0;
      guard++;
    end
    check({tag, "_empty"}, {31'd0, rd_valid}, 32'd0);
    check({tag, "_missing"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    // reset values
    cycles(3);
    @(negedge clk);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_rd_data", {24'd0, rd_data}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    cycles(5);

    // good frame 0x1C
    e0 = err_cnt;
    expect_byte(8'h1C);
    send_frame(8'h1C, odd_par(8'h1C), 1'b1, 1'b0);
    drain("good_1c");
    check("good_1c_err", err_cnt - e0, 32'd0);

    // 0x1C with wrong parity
    e0 = err_cnt;
`ifdef PS2_PARITY_CHECK_EN
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    drain("badpar");
    check("badpar_err", err_cnt - e0, 32'd1);
`else
    expect_byte(8'h1C);
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    drain("badpar");
    check("badpar_err", err_cnt - e0, 32'd0);
`endif

    // bad stop bit
    e0 = err_cnt;
    send_frame(8'h33, odd_par(8'h33), 1'b0, 1'b0);
    drain("badstop");
    check("badstop_err", err_cnt - e0, 32'd1);

    // pop attempts while empty are ignored
    @(negedge clk);
    rd_ready = 1'b1;
    cycles(3);
    @(negedge clk);
    rd_ready = 1'b0;
    check("empty_pop_valid", {31'd0, rd_valid}, 32'd0);

    // overflow: five frames into a four-deep FIFO
    for (int b = 1; b <= 5; b++) begin
      expect_byte(8'(b));
      send_frame(8'(b), odd_par(8'(b)), 1'b1, 1'b0);
    end
    @(negedge clk);
    check("ovf_set", {31'd0, ovf}, {31'd0, model_ovf});
    drain("ovf_fifo");
    check("ovf_sticky", {31'd0, ovf}, 32'd1);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    model_ovf = 1'b0;
    check("ovf_clr", {31'd0, ovf}, 32'd0);

    // timeout after four data bits, then a clean 0xF0
    e0 = err_cnt;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    ps2_data = 1'b1;
    @(negedge clk);
    check("to_busy_mid", {31'd0, busy}, 32'd1);
    cycles(TO + 40);
    @(negedge clk);
    check("to_err", err_cnt - e0, 32'd1);
    check("to_busy_after", {31'd0, busy}, 32'd0);
    check("to_no_data", {31'd0, rd_valid}, 32'd0);
    expect_byte(8'hF0);
    send_frame(8'hF0, odd_par(8'hF0), 1'b1, 1'b0);
    drain("after_to");
    check("after_to_err", err_cnt - e0, 32'd1);

    // glitches shorter than the filter length
    e0 = err_cnt;
    expect_byte(8'h5A);
    send_frame(8'h5A, odd_par(8'h5A), 1'b1, 1'b1);
    drain("glitch");
    check("glitch_err", err_cnt - e0, 32'd0);

    // reset in the middle of a frame
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    cycles(2);
    @(negedge clk);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_state", {30'd0, dbg_state}, 32'd0);
    check("mid_rst_valid", {31'd0, rd_valid}, 32'd0);
    check("mid_rst_data", {24'd0, rd_data}, 32'd0);
    check("mid_rst_err", {31'd0, frame_err}, 32'd0);
    check("mid_rst_ovf", {31'd0, ovf}, 32'd0);
    rst = 1'b0;
    cycles(5);
    e0 = err_cnt;
    expect_byte(8'hAA);
    send_frame(8'hAA, odd_par(8'hAA), 1'b1, 1'b0);
    drain("post_rst");
    check("post_rst_err", err_cnt - e0, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
